// File: rtl/s27_seq_harness.sv
// Sequential harness around the split s27 core: LFSR drives pi0..pi3, a 3-bit state register closes the loop, MISR compacts po0..po3.
// Latency: start at edge t, vector 0 presented in cycle t+1, NUM_VECTORS RUN cycles, done from the cycle after the last vector edge.
// Backpressure: none; the core is purely combinational and start is ignored while a run is in progress.
module s27_seq_harness #(
    parameter int unsigned  NUM_VECTORS = 256,
    parameter logic [15:0]  SEED        = 16'hACE1,
    parameter logic [15:0]  GOLDEN      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [6:0]  core_pi,
    input  logic [3:0]  core_po,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic        sig_match,
    output logic [15:0] vec_count
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] LP_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
    // A zero-length run is meaningless; it behaves as a single vector.
    localparam logic [15:0] LP_NUM_VEC = (NUM_VECTORS == 0) ? 16'd1 : 16'(NUM_VECTORS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_fsm;
    state_t      w_fsm_nxt;
    logic [15:0] r_lfsr;
    logic [2:0]  r_state;
    logic [15:0] r_misr;
    logic [15:0] r_vec_cnt;

    logic        w_lfsr_fb;
    logic        w_misr_fb;
    logic [15:0] w_lfsr_nxt;
    logic [15:0] w_misr_nxt;
    logic [15:0] w_vec_inc;
    logic        w_last_vec;
    logic        w_reload;
    logic        w_run;

    assign w_run      = (r_fsm == ST_RUN);
    // A start seen outside RUN reloads the whole datapath for a fresh run.
    assign w_reload   = start && !w_run;

    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_nxt = {r_lfsr[14:0], w_lfsr_fb};
    assign w_misr_fb  = r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10];
    assign w_misr_nxt = {r_misr[14:0], w_misr_fb} ^ {12'h000, core_po};
    assign w_vec_inc  = r_vec_cnt + 16'd1;
    assign w_last_vec = (w_vec_inc == LP_NUM_VEC);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state logic: RUN ends on the edge that applies the final vector.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE: if (start)      w_fsm_nxt = ST_RUN;
            ST_RUN:  if (w_last_vec) w_fsm_nxt = ST_DONE;
            ST_DONE: if (start)      w_fsm_nxt = ST_RUN;
            default:                 w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Datapath: reload on run entry, step once per RUN cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr    <= LP_SEED;
            r_state   <= 3'b000;
            r_misr    <= 16'h0000;
            r_vec_cnt <= 16'd0;
        end else if (w_reload) begin
            r_lfsr    <= LP_SEED;
            r_state   <= 3'b000;
            r_misr    <= 16'h0000;
            r_vec_cnt <= 16'd0;
        end else if (w_run) begin
            r_lfsr    <= w_lfsr_nxt;
            r_state   <= core_po[3:1];
            r_misr    <= w_misr_nxt;
            r_vec_cnt <= w_vec_inc;
        end
    end

    assign core_pi   = {r_state, r_lfsr[3:0]};
    assign busy      = w_run;
    assign done      = (r_fsm == ST_DONE);
    assign signature = r_misr;
    assign sig_match = done && (r_misr == GOLDEN);
    assign vec_count = r_vec_cnt;

endmodule
